// File: rtl/reorder_buffer_mc_if.sv
// rtl/reorder_buffer_mc_if.sv - dispatch, lookup, CDB, commit and flush bundle of the reorder buffer
interface reorder_buffer_mc_if #(
    parameter int IDX_W     = 4,
    parameter int CDB_PORTS = 2
);
    // dispatch
    logic                       disp_valid;
    logic                       disp_ready;
    logic [4:0]                 disp_rd;
    logic [31:0]                disp_pc;
    logic [31:0]                disp_inst;
    logic [IDX_W-1:0]           disp_tag;
    logic                       full;
    logic                       empty;
    // source-operand lookup
    logic [IDX_W-1:0]           rd_tag0;
    logic [IDX_W-1:0]           rd_tag1;
    logic                       rd_ready0;
    logic                       rd_ready1;
    logic [31:0]                rd_data0;
    logic [31:0]                rd_data1;
    // common data bus write-back
    logic [CDB_PORTS-1:0]       cdb_valid;
    logic [CDB_PORTS*IDX_W-1:0] cdb_tag;
    logic [CDB_PORTS*32-1:0]    cdb_data;
    logic [CDB_PORTS-1:0]       cdb_exc;
    // in-order commit
    logic                       commit0_valid;
    logic [4:0]                 commit0_rd;
    logic [31:0]                commit0_data;
    logic [IDX_W-1:0]           commit0_tag;
    logic                       commit1_valid;
    logic [4:0]                 commit1_rd;
    logic [31:0]                commit1_data;
    logic [IDX_W-1:0]           commit1_tag;
    // flush
    logic                       flush_in;
    logic                       flush_out;
    logic [31:0]                flush_pc;

    modport master (
        output disp_valid, disp_rd, disp_pc, disp_inst,
        input  disp_ready, disp_tag, full, empty,
        output rd_tag0, rd_tag1,
        input  rd_ready0, rd_ready1, rd_data0, rd_data1,
        output cdb_valid, cdb_tag, cdb_data, cdb_exc,
        input  commit0_valid, commit0_rd, commit0_data, commit0_tag,
        input  commit1_valid, commit1_rd, commit1_data, commit1_tag,
        output flush_in,
        input  flush_out, flush_pc
    );

    modport slave (
        input  disp_valid, disp_rd, disp_pc, disp_inst,
        output disp_ready, disp_tag, full, empty,
        input  rd_tag0, rd_tag1,
        output rd_ready0, rd_ready1, rd_data0, rd_data1,
        input  cdb_valid, cdb_tag, cdb_data, cdb_exc,
        output commit0_valid, commit0_rd, commit0_data, commit0_tag,
        output commit1_valid, commit1_rd, commit1_data, commit1_tag,
        input  flush_in,
        output flush_out, flush_pc
    );
endinterface

// File: rtl/reorder_buffer_mc.sv
// rtl/reorder_buffer_mc.sv - multi-CDB, dual-commit reorder buffer with precise exception flush
module reorder_buffer_mc #(
    parameter int DEPTH       = 16,
    parameter int IDX_W       = $clog2(DEPTH),
    parameter int CDB_PORTS   = 2,
    parameter int DUAL_COMMIT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    reorder_buffer_mc_if.slave bus
);
    localparam bit                 DUAL     = (DUAL_COMMIT != 0);
    localparam logic [IDX_W:0]     CNT_FULL = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]     CNT_TWO  = (IDX_W+1)'(2);

    // Per-entry status flags
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] ready_q, ready_d;
    logic [DEPTH-1:0] exc_q,   exc_d;

    // Per-entry payload; only meaningful while the matching valid bit is set
    logic [4:0]       rd_q    [DEPTH];
    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      value_q [DEPTH];

    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [IDX_W:0]   count_q, count_d;
    logic [IDX_W-1:0] head1;

    // Registered commit and flush outputs
    logic             c0_valid_q;
    logic [4:0]       c0_rd_q;
    logic [31:0]      c0_data_q;
    logic [IDX_W-1:0] c0_tag_q;
    logic             c1_valid_q;
    logic [4:0]       c1_rd_q;
    logic [31:0]      c1_data_q;
    logic [IDX_W-1:0] c1_tag_q;
    logic             flush_out_q;
    logic [31:0]      flush_pc_q;

    // Unpacked views of the CDB ports
    logic [IDX_W-1:0] cdb_tag_w  [CDB_PORTS];
    logic [31:0]      cdb_data_w [CDB_PORTS];

    logic full_w, empty_w;
    logic exc_take, commit0, commit1, flush_all, disp_acc;
    logic hit0, hit1;
    logic [31:0] hit0_data, hit1_data;

    // Split the packed CDB buses into per-port fields
    always_comb begin
        for (int p = 0; p < CDB_PORTS; p++) begin
            cdb_tag_w[p]  = bus.cdb_tag[p*IDX_W +: IDX_W];
            cdb_data_w[p] = bus.cdb_data[p*32 +: 32];
        end
    end

    assign full_w  = (count_q == CNT_FULL);
    assign empty_w = (count_q == '0);
    assign head1   = head_q + IDX_W'(1);

    // Retirement decisions look only at registered Ready/Exc, never at this cycle's CDB
    always_comb begin
        exc_take  = ~empty_w && ready_q[head_q] && exc_q[head_q];
        commit0   = ~empty_w && ready_q[head_q] && ~exc_q[head_q] && ~bus.flush_in;
        commit1   = DUAL && commit0 && (count_q >= CNT_TWO)
                    && ready_q[head1] && ~exc_q[head1];
        flush_all = bus.flush_in || exc_take;
        disp_acc  = bus.disp_valid && ~full_w && ~flush_all;
    end

    // Pointer and occupancy next state; a flush of either kind empties the buffer
    always_comb begin
        head_d  = head_q + IDX_W'(commit0) + IDX_W'(commit1);
        tail_d  = tail_q + IDX_W'(disp_acc);
        count_d = count_q + (IDX_W+1)'(disp_acc) - (IDX_W+1)'(commit0) - (IDX_W+1)'(commit1);
        if (flush_all) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Status-flag next state: CDB completion, dispatch allocation, then retirement release
    always_comb begin
        valid_d = valid_q;
        ready_d = ready_q;
        exc_d   = exc_q;
        if (flush_all) begin
            valid_d = '0;
            ready_d = '0;
            exc_d   = '0;
        end else begin
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (bus.cdb_valid[p] && valid_q[cdb_tag_w[p]]) begin
                    ready_d[cdb_tag_w[p]] = 1'b1;
                    exc_d[cdb_tag_w[p]]   = bus.cdb_exc[p];
                end
            end
            if (disp_acc) begin
                valid_d[tail_q] = 1'b1;
                ready_d[tail_q] = 1'b0;
                exc_d[tail_q]   = 1'b0;
            end
            if (commit0) begin
                valid_d[head_q] = 1'b0;
                ready_d[head_q] = 1'b0;
            end
            if (commit1) begin
                valid_d[head1] = 1'b0;
                ready_d[head1] = 1'b0;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ready_q <= '0;
            exc_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            ready_q <= ready_d;
            exc_q   <= exc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage; later CDB ports are written last so the highest index wins a tag collision
    always_ff @(posedge clk) begin
        if (!flush_all) begin
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (bus.cdb_valid[p] && valid_q[cdb_tag_w[p]]) begin
                    value_q[cdb_tag_w[p]] <= cdb_data_w[p];
                end
            end
            if (disp_acc) begin
                rd_q[tail_q] <= bus.disp_rd;
                pc_q[tail_q] <= bus.disp_pc;
            end
        end
    end

    // Registered commit payloads and exception flush pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c0_valid_q  <= 1'b0;
            c0_rd_q     <= '0;
            c0_data_q   <= '0;
            c0_tag_q    <= '0;
            c1_valid_q  <= 1'b0;
            c1_rd_q     <= '0;
            c1_data_q   <= '0;
            c1_tag_q    <= '0;
            flush_out_q <= 1'b0;
            flush_pc_q  <= '0;
        end else begin
            c0_valid_q  <= commit0;
            c0_rd_q     <= commit0 ? rd_q[head_q]    : '0;
            c0_data_q   <= commit0 ? value_q[head_q] : '0;
            c0_tag_q    <= commit0 ? head_q          : '0;
            c1_valid_q  <= commit1;
            c1_rd_q     <= commit1 ? rd_q[head1]     : '0;
            c1_data_q   <= commit1 ? value_q[head1]  : '0;
            c1_tag_q    <= commit1 ? head1           : '0;
            flush_out_q <= exc_take && ~bus.flush_in;
            flush_pc_q  <= (exc_take && ~bus.flush_in) ? pc_q[head_q] : '0;
        end
    end

    // Operand lookup: a same-cycle CDB hit beats stored state, lowest port first
    always_comb begin
        hit0      = 1'b0;
        hit1      = 1'b0;
        hit0_data = '0;
        hit1_data = '0;
        for (int p = CDB_PORTS-1; p >= 0; p--) begin
            if (bus.cdb_valid[p] && (cdb_tag_w[p] == bus.rd_tag0)) begin
                hit0      = 1'b1;
                hit0_data = cdb_data_w[p];
            end
            if (bus.cdb_valid[p] && (cdb_tag_w[p] == bus.rd_tag1)) begin
                hit1      = 1'b1;
                hit1_data = cdb_data_w[p];
            end
        end
        bus.rd_ready0 = valid_q[bus.rd_tag0] && (ready_q[bus.rd_tag0] || hit0);
        bus.rd_ready1 = valid_q[bus.rd_tag1] && (ready_q[bus.rd_tag1] || hit1);
        bus.rd_data0  = !bus.rd_ready0 ? 32'h0 : (hit0 ? hit0_data : value_q[bus.rd_tag0]);
        bus.rd_data1  = !bus.rd_ready1 ? 32'h0 : (hit1 ? hit1_data : value_q[bus.rd_tag1]);
    end

    assign bus.disp_ready    = ~full_w;
    assign bus.disp_tag      = tail_q;
    assign bus.full          = full_w;
    assign bus.empty         = empty_w;
    assign bus.commit0_valid = c0_valid_q;
    assign bus.commit0_rd    = c0_rd_q;
    assign bus.commit0_data  = c0_data_q;
    assign bus.commit0_tag   = c0_tag_q;
    assign bus.commit1_valid = c1_valid_q;
    assign bus.commit1_rd    = c1_rd_q;
    assign bus.commit1_data  = c1_data_q;
    assign bus.commit1_tag   = c1_tag_q;
    assign bus.flush_out     = flush_out_q;
    assign bus.flush_pc      = flush_pc_q;
endmodule
